// File: rtl/conv_window_line_buffer.sv
// conv_window_line_buffer
//
// Upstream stage of the 3x3 edge-detector convolution unit. Takes a row-major
// raster stream of unsigned pixels, keeps the two previous rows in line
// buffers and the two previous columns of the current neighbourhood in a
// small shift window. Every pixel at (r,c) with r>=2 and c>=2 completes a
// 3x3 neighbourhood, which is presented on pixel_0..pixel_8 with a
// valid/ready handshake. No padding is generated at image borders.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous, active-high reset
//   in_pixel/in_valid   raster pixel input; taken when in_valid && in_ready
//   in_ready            combinational: !out_valid || out_ready
//   pixel_0..pixel_8    3x3 window, row-major (pixel_0 top-left,
//                       pixel_8 bottom-right)
//   out_valid/out_ready window handshake; window is held while stalled
//   frame_done          one-cycle pulse after the last window of a frame
//                       has been taken
module conv_window_line_buffer #(
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned IMG_HEIGHT = 8,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_valid,
    output logic              in_ready,

    output logic [DATA_W-1:0] pixel_0,
    output logic [DATA_W-1:0] pixel_1,
    output logic [DATA_W-1:0] pixel_2,
    output logic [DATA_W-1:0] pixel_3,
    output logic [DATA_W-1:0] pixel_4,
    output logic [DATA_W-1:0] pixel_5,
    output logic [DATA_W-1:0] pixel_6,
    output logic [DATA_W-1:0] pixel_7,
    output logic [DATA_W-1:0] pixel_8,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done
);

    localparam int unsigned ColW = $clog2(IMG_WIDTH);
    localparam int unsigned RowW = $clog2(IMG_HEIGHT);

    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
    localparam logic [ColW-1:0] ColTwo  = ColW'(2);
    localparam logic [RowW-1:0] RowTwo  = RowW'(2);

    typedef enum logic [1:0] {
        StFill,
        StRun,
        StHold
    } state_e;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_e state_q, state_d;

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;

    // lb_mid holds row r-1, lb_top holds row r-2, both indexed by column.
    logic [DATA_W-1:0] lb_mid_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb_top_q [IMG_WIDTH];

    // Shift window: tap_a is column c-2, tap_b is column c-1; index 0 is the
    // top row, 2 the bottom row.
    logic [DATA_W-1:0] tap_a_q [3];
    logic [DATA_W-1:0] tap_a_d [3];
    logic [DATA_W-1:0] tap_b_q [3];
    logic [DATA_W-1:0] tap_b_d [3];
    logic [DATA_W-1:0] new_col [3];

    logic [DATA_W-1:0] pix_q [9];
    logic [DATA_W-1:0] pix_d [9];

    logic out_valid_q, out_valid_d;
    logic last_q, last_d;
    logic frame_done_q, frame_done_d;

    logic accept;
    logic win_fire;
    logic cur_pos_run;
    logic next_pos_run;

    // ------------------------------------------------------------------
    // Position bookkeeping
    // ------------------------------------------------------------------
    assign accept = in_valid && in_ready;

    // The pixel at the current (row_q, col_q) would complete a window.
    assign cur_pos_run  = (row_q >= RowTwo) && (col_q >= ColTwo);
    assign next_pos_run = (row_d >= RowTwo) && (col_d >= ColTwo);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // Outside of StHold the state mirrors whether the next pixel to arrive
    // completes a window (StRun) or only primes the buffers (StFill).
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill, StRun: begin
                if (accept) begin
                    state_d = next_pos_run ? StRun : StFill;
                end else if (out_valid_q && !out_ready) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = next_pos_run ? StRun : StFill;
                    end else begin
                        state_d = cur_pos_run ? StRun : StFill;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        win_fire = 1'b0;
        unique case (state_q)
            StRun:   win_fire = accept;
            // Released from a stall in the same cycle a pixel arrives.
            StHold:  win_fire = accept && cur_pos_run;
            default: win_fire = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Window datapath
    // ------------------------------------------------------------------
    assign new_col[0] = lb_top_q[col_q];
    assign new_col[1] = lb_mid_q[col_q];
    assign new_col[2] = in_pixel;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tap_a_d[i] = tap_a_q[i];
            tap_b_d[i] = tap_b_q[i];
            if (accept) begin
                tap_a_d[i] = tap_b_q[i];
                tap_b_d[i] = new_col[i];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            pix_d[k] = pix_q[k];
        end
        out_valid_d  = out_valid_q;
        last_d       = last_q;
        frame_done_d = out_valid_q && out_ready && last_q;

        if (win_fire) begin
            for (int i = 0; i < 3; i++) begin
                pix_d[3*i]     = tap_a_q[i];
                pix_d[3*i + 1] = tap_b_q[i];
                pix_d[3*i + 2] = new_col[i];
            end
            out_valid_d = 1'b1;
            last_d      = (row_q == RowLast) && (col_q == ColLast);
        end else if (out_ready) begin
            // Either the window was taken, or nothing was showing.
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: contents are only ever read once two full rows of the
    // current frame have been written, so they need no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top_q[col_q] <= lb_mid_q[col_q];
            lb_mid_q[col_q] <= in_pixel;
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                tap_a_q[i] <= '0;
                tap_b_q[i] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                pix_q[k] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 3; i++) begin
                tap_a_q[i] <= tap_a_d[i];
                tap_b_q[i] <= tap_b_d[i];
            end
            for (int k = 0; k < 9; k++) begin
                pix_q[k] <= pix_d[k];
            end
        end
    end

    assign pixel_0    = pix_q[0];
    assign pixel_1    = pix_q[1];
    assign pixel_2    = pix_q[2];
    assign pixel_3    = pix_q[3];
    assign pixel_4    = pix_q[4];
    assign pixel_5    = pix_q[5];
    assign pixel_6    = pix_q[6];
    assign pixel_7    = pix_q[7];
    assign pixel_8    = pix_q[8];
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_line_buffer.sv
// Testbench for conv_window_line_buffer: a 4x4 instance for the handshake
// and frame sequences, and a default 8x8 instance for full-size windows.
module tb_conv_window_line_buffer;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] in_pixel;
    logic          in_valid, in_ready, out_valid, out_ready, frame_done;
    logic [DW-1:0] p [9];

    logic [DW-1:0] b_in_pixel;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
    logic [DW-1:0] b_p [9];

    conv_window_line_buffer #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(4),
        .DATA_W    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel_0   (p[0]),
        .pixel_1   (p[1]),
        .pixel_2   (p[2]),
        .pixel_3   (p[3]),
        .pixel_4   (p[4]),
        .pixel_5   (p[5]),
        .pixel_6   (p[6]),
        .pixel_7   (p[7]),
        .pixel_8   (p[8]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_done(frame_done)
    );

    conv_window_line_buffer dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_pixel  (b_in_pixel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .pixel_0   (b_p[0]),
        .pixel_1   (b_p[1]),
        .pixel_2   (b_p[2]),
        .pixel_3   (b_p[3]),
        .pixel_4   (b_p[4]),
        .pixel_5   (b_p[5]),
        .pixel_6   (b_p[6]),
        .pixel_7   (b_p[7]),
        .pixel_8   (b_p[8]),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .frame_done(b_frame_done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected windows of a 4x4 frame with pixel(r,c) = 4r+c, keyed by the
    // position of the completing pixel.
    typedef struct {
        int          r;
        int          c;
        logic [71:0] exp;
    } vec_t;
    vec_t tbl [4];

    logic [71:0] got_q [$];
    logic [71:0] b_got_q [$];
    int hs_cnt   = 0;
    int fd_cnt   = 0;
    int b_fd_cnt = 0;
    bit fd_exp   = 1'b0;

    function automatic logic [71:0] pack9(input logic [DW-1:0] a [9]);
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[71-8*i -: 8] = a[i];
        return v;
    endfunction

    function automatic logic [71:0] add_off(input logic [71:0] v, input int off);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[8*i +: 8] = v[8*i +: 8] + 8'(off);
        return r;
    endfunction

    task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Window capture and frame_done timing for the 4x4 instance. Sampled on
    // the falling edge; a handshake seen here completes on the next rise.
    always @(negedge clk) begin
        if (rst) begin
            hs_cnt = 0;
            fd_exp = 1'b0;
        end else begin
            if (frame_done || fd_exp) chk1("frame_done_timing", frame_done, fd_exp);
            if (frame_done) fd_cnt++;
            fd_exp = 1'b0;
            if (out_valid && out_ready) begin
                got_q.push_back(pack9(p));
                hs_cnt++;
                fd_exp = (hs_cnt % 4 == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_out_valid && b_out_ready) b_got_q.push_back(pack9(b_p));
            if (b_frame_done) b_fd_cnt++;
        end
    end

    // Present one pixel and wait (bounded) until it is accepted. Called and
    // returns 1 time unit after a rising edge.
    task automatic send_px(input logic [DW-1:0] v, input bit gaps);
        int n;
        if (gaps) begin
            n = 0;
            while ($urandom_range(1) == 1 && n < 8) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                n++;
            end
        end
        in_pixel = v;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: pixel %0d not accepted, got in_ready=0, expected 1", v);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int off, input bit gaps);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                send_px(8'(off + 4*r + c), gaps);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int first, input int off);
        for (int k = 0; k < 4; k++)
            chk_w($sformatf("%s_win_r%0d_c%0d", tag, tbl[k].r, tbl[k].c),
                  got_q[first+k], add_off(tbl[k].exp, off));
    endtask

    task automatic check_reset(input string tag);
        logic [71:0] zero;
        zero = '0;
        chk1({tag, "_out_valid"}, out_valid, 0);
        chk1({tag, "_frame_done"}, frame_done, 0);
        chk1({tag, "_in_ready"}, in_ready, 1);
        chk_w({tag, "_window"}, pack9(p), zero);
    endtask

    initial begin
        logic [71:0] first;
        int n;

        tbl[0] = '{2, 2, {8'd0, 8'd1, 8'd2,  8'd4, 8'd5,  8'd6,  8'd8,  8'd9,  8'd10}};
        tbl[1] = '{2, 3, {8'd1, 8'd2, 8'd3,  8'd5, 8'd6,  8'd7,  8'd9,  8'd10, 8'd11}};
        tbl[2] = '{3, 2, {8'd4, 8'd5, 8'd6,  8'd8, 8'd9,  8'd10, 8'd12, 8'd13, 8'd14}};
        tbl[3] = '{3, 3, {8'd5, 8'd6, 8'd7,  8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}};

        rst         = 1'b1;
        in_pixel    = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        b_in_pixel  = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;

        @(posedge clk);
        #1;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming frame with latency checks around the first window.
        got_q.delete();
        fd_cnt = 0;
        for (int idx = 0; idx < 16; idx++) begin
            send_px(8'(idx), 1'b0);
            if (idx == 9) chk1("latency_before_first", out_valid, 0);
            if (idx == 10) begin
                chk1("latency_first_valid", out_valid, 1);
                chk_w("latency_first_window", pack9(p), tbl[0].exp);
            end
        end
        drain();
        chk1("stream_count", got_q.size(), 4);
        check_frame("stream", 0, 0);
        chk1("stream_frame_done_cnt", fd_cnt, 1);

        // Back-pressure: hold the first window for 5 cycles.
        got_q.delete();
        out_ready = 1'b0;
        fork
            send_frame(0, 1'b0);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 300);
                chk1("hold_seen", out_valid, 1);
                first = pack9(p);
                chk_w("hold_first", first, tbl[0].exp);
                for (int i = 0; i < 5; i++) begin
                    chk1("hold_in_ready", in_ready, 0);
                    chk1("hold_out_valid", out_valid, 1);
                    chk_w("hold_stable", pack9(p), first);
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk1("hold_count", got_q.size(), 4);
        check_frame("hold", 0, 0);

        // Random input gaps.
        got_q.delete();
        fd_cnt = 0;
        send_frame(0, 1'b1);
        drain();
        chk1("gaps_count", got_q.size(), 4);
        check_frame("gaps", 0, 0);
        chk1("gaps_frame_done_cnt", fd_cnt, 1);

        // Two back-to-back frames.
        got_q.delete();
        fd_cnt = 0;
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        drain();
        chk1("b2b_count", got_q.size(), 8);
        check_frame("b2b_f0", 0, 0);
        check_frame("b2b_f1", 4, 100);
        chk1("b2b_frame_done_cnt", fd_cnt, 2);

        // Asynchronous reset after 7 pixels, then a fresh frame.
        for (int idx = 0; idx < 7; idx++) send_px(8'(idx), 1'b0);
        #2 rst = 1'b1;
        #1 check_reset("rst7");
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        fd_cnt = 0;
        send_frame(0, 1'b0);
        drain();
        chk1("rst7_count", got_q.size(), 4);
        check_frame("rst7", 0, 0);
        chk1("rst7_frame_done_cnt", fd_cnt, 1);

        // Reset while a window is being held.
        out_ready = 1'b0;
        for (int idx = 0; idx < 11; idx++) send_px(8'(idx), 1'b0);
        chk1("rsthold_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1 check_reset("rsthold");
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        send_frame(0, 1'b0);
        drain();
        chk1("rsthold_count", got_q.size(), 4);
        check_frame("rsthold", 0, 0);

        // Default 8x8 instance.
        b_got_q.delete();
        b_fd_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            b_in_pixel = 8'(i);
            b_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        drain();
        chk1("img8_count", b_got_q.size(), 36);
        chk_w("img8_first", b_got_q[0],
              {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18});
        chk_w("img8_last", b_got_q[35],
              {8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63});
        chk1("img8_frame_done_cnt", b_fd_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_line_buffer.md
Name: conv_window_line_buffer

Overview:
- Upstream stage of the 3x3 edge-detector convolution unit.
- Accepts an unsigned 8-bit raster pixel stream (row-major, one pixel per accepted beat) and keeps two full-row line buffers plus a 3x3 shift window.
- Presents each complete 3x3 neighbourhood as nine parallel pixels with a valid/ready handshake.
- Back-pressure lets the single-MAC convolution consumer take multiple cycles per window.

Parameters:
- IMG_WIDTH, 8, pixels per row (>=3)
- IMG_HEIGHT, 8, rows per frame (>=3)
- DATA_W, 8, pixel width in bits

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_pixel  input  DATA_W  raster pixel
- in_valid  input  1  in_pixel is valid
- in_ready  output  1  block can accept a pixel this cycle
- pixel_0..pixel_8  output  DATA_W each  3x3 window, row-major; pixel_0 = top-left, pixel_8 = bottom-right
- out_valid  output  1  window on pixel_0..8 is valid
- out_ready  input  1  consumer takes the window this cycle
- frame_done  output  1  one-cycle pulse when the last window of a frame is taken

Behaviour:
- Reset (async, any time including mid-frame):
  - out_valid=0, frame_done=0, pixel_0..8=0.
  - Column/row counters=0; FSM to S_FILL.
  - Line buffer contents need not be cleared; stale data is never exposed.
  - in_ready=1 during and after reset.
- Accept: a pixel is taken when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, combinational.
  - The pixel is written to the line buffers and the window shifts.
  - col increments and wraps IMG_WIDTH-1 -> 0 with row+1.
  - row wraps IMG_HEIGHT-1 -> 0, starting a new frame.
- Window mapping for an accepted pixel at (r,c):
  - pixel_{3i+j} = image(r-2+i, c-2+j) for i,j in 0..2.
  - Valid windows only, no padding: a window is produced iff r>=2 && c>=2.
  - (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- Latency: the window completed by a pixel accepted at edge N is on the outputs, with out_valid=1, after edge N (visible the cycle after acceptance).
- Hold: while out_valid && !out_ready:
  - pixel_0..8 and out_valid stay stable.
  - in_ready=0; no pixel is lost or overwritten.
- Same-cycle hand-off: out_valid && out_ready with an accepted pixel that completes a new window -> out_valid stays 1 and outputs update to the new window.
  - If the accepted pixel does not complete a window, out_valid -> 0.
- frame_done: 1 for exactly the cycle after the hand-off (out_valid && out_ready) of the window at (IMG_HEIGHT-1, IMG_WIDTH-1); otherwise 0.
- FSM:
  - S_FILL: row<2, or col<2 of the current row; no windows produced.
  - S_RUN: completing pixels generate windows.
  - S_HOLD: out_valid && !out_ready.
  - Transitions:
    - S_FILL -> S_RUN on accepting (r>=2, c=1).
    - S_RUN -> S_FILL at row wrap (new frame) or on accepting a col=IMG_WIDTH-1 pixel (next row's c<2).
    - S_RUN/S_FILL -> S_HOLD when out_valid asserts and out_ready=0.
    - S_HOLD -> S_RUN/S_FILL on out_ready, per next pixel position.
- in_valid gaps: no shift, no state change; out_valid is unaffected except by out_ready.
- Arithmetic: pixels pass through unmodified and unsigned; no sign extension. Counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits.

Test Plan:
- 4x4 image, pixel(r,c)=4r+c, in_valid=1, out_ready=1:
  - 4 windows.
  - First window appears the cycle after pixel 10 is accepted: 0,1,2,4,5,6,8,9,10.
  - Last window: 5,6,7,9,10,11,13,14,15; frame_done pulses once after it.
- Same stream, out_ready held 0 for 5 cycles after the first out_valid:
  - in_ready=0 and outputs are stable for those 5 cycles.
  - On release, the remaining windows match exactly; no pixel is skipped.
- Random in_valid (about 50%) with out_ready=1: window sequence identical to the first test; window count=4.
- Two back-to-back 4x4 frames, second with pixel=100+4r+c:
  - Second frame's first window is 100,101,102,104,105,106,108,109,110; no window mixes frames.
  - frame_done pulses twice.
- Assert rst after 7 pixels:
  - out_valid=0 and outputs=0 immediately.
  - A fresh frame then yields the first-test results exactly.
- Default 8x8, pixel=r*8+c: 36 windows; window at (7,7) = 45,46,47,53,54,55,61,62,63.
